// File: rtl/aes_round_controller.sv
// Sequences one AES-128 block through a shared single-round datapath: initial AddRoundKey, then NUM_ROUNDS rounds.
// Optional macro AES_BLOCK_COUNT_EN adds a saturating completed-block counter output blk_count.
module aes_round_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int DATA_W     = 128
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] plaintext,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        key_idx,
  input  logic [DATA_W-1:0] key_in,
  output logic [DATA_W-1:0] rnd_data,
  output logic [DATA_W-1:0] rnd_key,
  output logic              rnd_final,
  input  logic [DATA_W-1:0] rnd_result,
  output logic              busy
`ifdef AES_BLOCK_COUNT_EN
  ,
  output logic [15:0]       blk_count
`endif
);

  if (DATA_W != 128) begin : g_bad_data_w
    $error("aes_round_controller: DATA_W must be 128");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 14) begin : g_bad_num_rounds
    $error("aes_round_controller: NUM_ROUNDS must be in 1..14");
  end

  typedef enum logic [1:0] {
    IDLE,
    ADDKEY,
    ROUND,
    DONE
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_t            state;
  logic [DATA_W-1:0] state_reg;
  logic [3:0]        round_cnt;
  logic              in_round;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      state_reg <= '0;
      round_cnt <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready && !abort) begin
            state_reg <= plaintext;
            state     <= ADDKEY;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end else begin
            in_ready  <= 1'b1;
          end
        end
        ADDKEY, ROUND: begin
          if (abort) begin
            state     <= IDLE;
            round_cnt <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end else if (state == ADDKEY) begin
            state_reg <= state_reg ^ key_in;
            round_cnt <= 4'd1;
            state     <= ROUND;
          end else begin
            state_reg <= rnd_result;
            if (round_cnt == LAST_RND) begin
              state     <= DONE;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              round_cnt <= round_cnt + 4'd1;
            end
          end
        end
        DONE: begin
          // abort and a handshake both release the block; only the handshake counts it
          if (abort || out_ready) begin
            state     <= IDLE;
            round_cnt <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_round  = (state == ROUND);
  assign key_idx   = in_round ? round_cnt : 4'd0;
  assign rnd_data  = in_round ? state_reg : '0;
  assign rnd_key   = in_round ? key_in : '0;
  assign rnd_final = in_round && (round_cnt == LAST_RND);
  assign data_out  = (state == DONE) ? state_reg : '0;

`ifdef AES_BLOCK_COUNT_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      blk_count <= '0;
    end else if (out_valid && out_ready && !abort && blk_count != 16'hFFFF) begin
      blk_count <= blk_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_controller.sv
// Scoreboard bench for aes_round_controller: stub and FIPS-197 round datapaths, directed and random traffic.
// Define AES_BLOCK_COUNT_EN to also exercise blk_count.
module tb_aes_round_controller;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plaintext = '0;
  logic         abort = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;
  logic [3:0]   key_idx;
  logic [127:0] key_in;
  logic [127:0] rnd_data;
  logic [127:0] rnd_key;
  logic         rnd_final;
  logic [127:0] rnd_result;
  logic         busy;
`ifdef AES_BLOCK_COUNT_EN
  logic [15:0]  blk_count;
  int           cnt_model = 0;
`endif

  // datapath mode: 0 = data+1, 1 = keyed mixing stub, 2 = real AES round
  int           mode = 0;
  logic [127:0] key_tab [15];
  logic [7:0]   sb [256];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  aes_round_controller #(.NUM_ROUNDS(NR), .DATA_W(128)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plaintext (plaintext),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .key_idx   (key_idx),
    .key_in    (key_in),
    .rnd_data  (rnd_data),
    .rnd_key   (rnd_key),
    .rnd_final (rnd_final),
    .rnd_result(rnd_result),
    .busy      (busy)
`ifdef AES_BLOCK_COUNT_EN
    ,
    .blk_count (blk_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r + 4*((c + r) % 4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  task automatic load_aes_keys(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) key_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- environment datapath and reference ----------------
  function automatic logic [127:0] dp_round(input logic [127:0] s, input logic [127:0] k,
                                            input logic fin, input int m);
    case (m)
      0:       return s + 128'd1;
      1:       return ({s[126:0], s[127]} ^ k) + (fin ? 128'd3 : 128'd1);
      default: return aes_round(s, k, fin);
    endcase
  endfunction

  assign key_in     = key_tab[key_idx];
  assign rnd_result = dp_round(rnd_data, rnd_key, rnd_final, mode);

  // Whole-block encryption as defined: AddRoundKey(0), then rounds 1..NR with the last one final.
  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
    logic [127:0] s = pt ^ key_tab[0];
    for (int r = 1; r <= NR; r++) s = dp_round(s, key_tab[r], r == NR, mode);
    return s;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [127:0] exp_q [$];
  int           seq [$];
  int           fin_pos [$];
  int           acc_edge = 0;
  logic         prev_ov = 1'b0;
  logic         hold_valid = 1'b0;
  logic [127:0] hold_data = '0;
  int           ov_seen = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      exp_q.delete(); seq.delete(); fin_pos.delete();
      prev_ov = 1'b0; hold_valid = 1'b0;
`ifdef AES_BLOCK_COUNT_EN
      cnt_model = 0;
`endif
    end else begin
      if (out_valid) ov_seen++;
      if (hold_valid) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_data_out", data_out, hold_data);
      end
      hold_valid = out_valid && !out_ready && !abort;
      hold_data  = data_out;
      if (busy || out_valid) check("in_ready_low", in_ready, 0);
      if (busy) begin
        seq.push_back(int'(key_idx));
        if (rnd_final) fin_pos.push_back(seq.size() - 1);
      end else begin
        check("rnd_quiet", rnd_data | rnd_key | {127'b0, rnd_final} | {124'b0, key_idx}, 0);
      end
      if (out_valid && !prev_ov) begin
        int first_bad = -1;
        check("latency", cyc - acc_edge, NR + 1);
        check("key_seq_len", seq.size(), NR + 1);
        for (int i = seq.size() - 1; i >= 0; i--) if (seq[i] != i) first_bad = i;
        check("key_seq_first_bad", first_bad, -1);
        check("final_round_pos", (fin_pos.size() == 1) ? fin_pos[0] : -1, NR);
        seq.delete(); fin_pos.delete();
      end
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else check("data_out", data_out, exp_q.pop_front());
`ifdef AES_BLOCK_COUNT_EN
        check("blk_count", blk_count, cnt_model);
        if (cnt_model < 65535) cnt_model++;
`endif
      end
      if (abort && (busy || out_valid)) begin
        exp_q.delete(); seq.delete(); fin_pos.delete();
      end
      if (in_valid && in_ready && !abort) begin
        exp_q.push_back(ref_encrypt(plaintext));
        acc_edge = cyc + 1;
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt);
    logic acc;
    int   k = 0;
    in_valid  = 1'b1;
    plaintext = pt;
    acc = 1'b0;
    while (!acc && k < 40) begin
      acc = in_ready && !abort;
      tick();
      k++;
    end
    check("accept_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int lim);
    int k = 0;
    while (!out_valid && k < lim) begin tick(); k++; end
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic wait_kidx(input logic [3:0] target);
    int k = 0;
    while (key_idx != target && k < 30) begin tick(); k++; end
    check("key_idx_timeout", key_idx, target);
  endtask

  task automatic drain();
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (20) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_key_idx"}, key_idx, 0);
    check({tag, "_rnd"}, rnd_data | rnd_key | {127'b0, rnd_final}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    init_sbox();
    for (int i = 0; i < 15; i++) key_tab[i] = '0;

    // reset state
    repeat (2) tick();
    check_all_zero("reset");
    n_rst = 1'b1;
    tick();
    check("in_ready_after_reset", in_ready, 1);

    // stub: data+1, zero keys, plaintext 0
    mode = 0; out_ready = 1'b1;
    send(128'h0);
    wait_ov(30);
    check("stub_result", data_out, 128'h0A);
    drain();

    // FIPS-197 appendix vector
    mode = 2;
    load_aes_keys(128'h2b7e151628aed2a6abf7158809cf4f3c);
    send(128'h3243f6a8885a308d313198a2e0370734);
    wait_ov(30);
    check("fips197", data_out, 128'h3925841d02dc09fbdc118597196a0b32);
    drain();

    // backpressure with a second block pending
    mode = 0;
    for (int i = 0; i < 15; i++) key_tab[i] = '0;
    out_ready = 1'b0;
    send(128'h0);
    in_valid = 1'b1; plaintext = 128'h1;
    wait_ov(30);
    repeat (5) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_data_out", data_out, 128'h0A);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_ready_after_hs", in_ready, 1);
    check("bp_not_yet_busy", busy, 0);
    tick();
    check("bp_second_accepted", busy, 1);
    in_valid = 1'b0;
    wait_ov(30);
    check("bp_second_result", data_out, 128'h0B);
    drain();

    // abort mid-block, then a fresh block
    send(128'h0);
    wait_kidx(4'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    send(128'h5);
    wait_ov(30);
    check("after_abort_result", data_out, 128'h0F);
    drain();

    // reset mid-block
    send(128'h0);
    wait_kidx(4'd7);
    n_rst = 1'b0;
    tick();
    check_all_zero("midreset");
    n_rst = 1'b1;
    tick();
    check("midreset_idle", in_ready, 1);
    ov_seen = 0;
    repeat (20) tick();
    check("no_stale_output", ov_seen, 0);

    // randomized traffic with the keyed stub
    mode = 1;
    for (int i = 0; i < 15; i++) key_tab[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 1500; c++) begin
      if (in_ready) begin
        in_valid  = ($urandom % 3) != 0;
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        abort     = 1'b0;
      end else begin
        in_valid  = $urandom % 2;
        abort     = ($urandom % 30) == 0;
      end
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

`ifdef AES_BLOCK_COUNT_EN
    n_rst = 1'b0;
    tick();
    check("blk_count_reset", blk_count, 0);
    n_rst = 1'b1;
    tick();
    mode = 0;
    repeat (3) begin
      send(128'h0);
      wait_ov(30);
      tick();
    end
    send(128'h0);
    wait_kidx(4'd3);
    abort = 1'b1;
    tick();
    drain();
    check("blk_count_three", blk_count, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
